// File: rtl/autofire_ctrl.sv
// Autofire scheduler for one NES controller port.
// Sits between the port sampler and the joypad shift register. It owns a
// single shared autofire timebase and gates enabled buttons with it. The
// per-button enable mask is loaded from a config strobe or toggled in-game
// with the hotkey combo (Select + A / Select + B).
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_in       live buttons, synchronised to clk (bit0 A, bit1 B,
//                bit2 Select, bit3 Start, bits4-7 Up/Down/Left/Right)
//   cfg_we       one-cycle strobe loading cfg_en into the enable mask
//   cfg_en       new autofire enable mask
//   btn_out      buttons after autofire gating and combo masking (registered)
//   af_en        current autofire enable mask (registered)
//   toggle_pulse one-cycle pulse when the hotkey flips a mask bit (registered)
module autofire_ctrl #(
  parameter int unsigned FREQ       = 37_800_000,
  parameter int unsigned FIRERATE   = 10,
  parameter int unsigned HOTKEY     = 2,
  parameter logic [7:0]  AF_DEFAULT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_in,
  input  logic       cfg_we,
  input  logic [7:0] cfg_en,
  output logic [7:0] btn_out,
  output logic [7:0] af_en,
  output logic       toggle_pulse
);

  localparam int unsigned NB    = 8;
  localparam int unsigned DELAY = FREQ / FIRERATE / 2;
  localparam int unsigned TW    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DELAY - 1);
  localparam logic [NB-1:0] HK_MASK    = NB'(1) << HOTKEY;
  // Buttons hidden from the game while a combo is in progress.
  localparam logic [NB-1:0] COMBO_MASK = NB'(3) | HK_MASK;

  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;
  logic [NB-1:0] btn_prev_q, btn_prev_d;
  logic          combo_q, combo_d;
  logic [NB-1:0] btn_out_q, btn_out_d;
  logic [NB-1:0] af_en_q, af_en_d;
  logic          toggle_q, toggle_d;

  logic          af_active;
  logic          hk_held;
  logic [NB-1:0] rise;
  logic [NB-1:0] flip;

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q    <= '0;
      phase_q    <= 1'b0;
      btn_prev_q <= '0;
      combo_q    <= 1'b0;
      btn_out_q  <= '0;
      af_en_q    <= AF_DEFAULT;
      toggle_q   <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      btn_prev_q <= btn_prev_d;
      combo_q    <= combo_d;
      btn_out_q  <= btn_out_d;
      af_en_q    <= af_en_d;
      toggle_q   <= toggle_d;
    end
  end

  // Shared timebase: idles at zero until an enabled button is held, so a
  // fresh press always starts a new period while later joiners share it.
  always_comb begin
    timer_d   = timer_q;
    phase_d   = phase_q;
    af_active = |(btn_in & af_en_q);
    if (!af_active) begin
      timer_d = '0;
      phase_d = 1'b0;
    end else begin
      if (timer_q == '0) phase_d = ~phase_q;
      timer_d = (timer_q == TMAX) ? '0 : timer_q + TW'(1);
    end
  end

  // Hotkey edge detection, mask update and combo tracking.
  always_comb begin
    btn_prev_d = btn_in;
    hk_held    = |(btn_in & HK_MASK);
    rise       = btn_in & ~btn_prev_q;
    flip       = '0;
    if (hk_held) flip[1:0] = rise[1:0];

    af_en_d  = af_en_q;
    toggle_d = 1'b0;
    // A config write wins; a same-cycle hotkey toggle is discarded.
    if (cfg_we) begin
      af_en_d = cfg_en;
    end else if (|flip) begin
      af_en_d  = af_en_q ^ flip;
      toggle_d = 1'b1;
    end

    combo_d = combo_q;
    if (!hk_held)  combo_d = 1'b0;
    if (toggle_d)  combo_d = 1'b1;
  end

  // Output gating; masking uses the next combo value so the game never
  // sees the combo buttons, not even on the cycle the toggle happens.
  always_comb begin
    btn_out_d = btn_in & (~af_en_q | {NB{phase_q}});
    if (combo_d) btn_out_d = btn_out_d & ~COMBO_MASK;
  end

  assign btn_out      = btn_out_q;
  assign af_en        = af_en_q;
  assign toggle_pulse = toggle_q;

endmodule

// File: tb/tb_autofire_ctrl.sv
// Directed self-checking bench for autofire_ctrl with DELAY = 5 cycles.
module tb_autofire_ctrl;

  localparam int unsigned D = 5;

  logic       clk;
  logic       reset;
  logic [7:0] btn_in;
  logic       cfg_we;
  logic [7:0] cfg_en;
  logic [7:0] btn_out;
  logic [7:0] af_en;
  logic       toggle_pulse;

  int n_checks = 0;
  int n_fails  = 0;

  autofire_ctrl #(
    .FREQ       (100),
    .FIRERATE   (10),
    .HOTKEY     (2),
    .AF_DEFAULT (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .cfg_we       (cfg_we),
    .cfg_en       (cfg_en),
    .btn_out      (btn_out),
    .af_en        (af_en),
    .toggle_pulse (toggle_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] m);
    cfg_we = 1'b1;
    cfg_en = m;
    tick();
    cfg_we = 1'b0;
    chk("cfg_load", 32'(af_en), 32'(m));
  endtask

  // Expected autofire output i edges after the first sampled press.
  function automatic logic af_exp(input int i);
    return (i > 0) && ((((i - 1) / D) % 2) == 0);
  endfunction

  initial begin
    reset  = 1'b1;
    btn_in = 8'h00;
    cfg_we = 1'b0;
    cfg_en = 8'h00;
    #2;
    chk("rst_btn_out", 32'(btn_out), 32'h00);
    chk("rst_af_en", 32'(af_en), 32'h00);
    chk("rst_toggle", 32'(toggle_pulse), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Plain pass-through
    btn_in = 8'h09;
    tick();
    chk("pass_press", 32'(btn_out), 32'h09);
    btn_in = 8'h00;
    tick();
    chk("pass_release", 32'(btn_out), 32'h00);

    // Autofire on A
    load_cfg(8'h01);
    btn_in = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("af_a_%0d", i), 32'(btn_out), 32'(af_exp(i)));
    end
    btn_in = 8'h00;
    tick();
    chk("af_a_release", 32'(btn_out), 32'h00);
    // Re-press starts a fresh period.
    btn_in = 8'h01;
    tick();
    chk("af_a_repress0", 32'(btn_out), 32'h00);
    tick();
    chk("af_a_repress1", 32'(btn_out), 32'h01);
    btn_in = 8'h00;
    tick();

    // Shared phase: B joins 7 cycles in, A released later
    load_cfg(8'h03);
    btn_in = 8'h01;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] e;
      if (i == 7)  btn_in = 8'h03;
      if (i == 20) btn_in = 8'h02;
      tick();
      if (i < 7)       e = {7'b0, af_exp(i)};
      else if (i < 20) e = {6'b0, af_exp(i), af_exp(i)};
      else             e = {6'b0, af_exp(i), 1'b0};
      chk($sformatf("shared_%0d", i), 32'(btn_out), 32'(e));
    end
    btn_in = 8'h00;
    tick();

    // Hotkey toggle
    load_cfg(8'h00);
    btn_in = 8'h04;
    tick();
    chk("hk_select_pass", 32'(btn_out), 32'h04);
    btn_in = 8'h05;
    tick();
    chk("hk_af_en_on", 32'(af_en), 32'h01);
    chk("hk_pulse_on", 32'(toggle_pulse), 32'h1);
    chk("hk_mask_0", 32'(btn_out), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hk_pulse_off", 32'(toggle_pulse), 32'h0);
      chk("hk_mask_hold", 32'(btn_out), 32'h00);
    end
    chk("hk_af_en_hold", 32'(af_en), 32'h01);
    btn_in = 8'h00;
    tick();
    chk("hk_release", 32'(btn_out), 32'h00);
    btn_in = 8'h04;
    tick();
    chk("hk_combo_clr", 32'(btn_out), 32'h04);
    btn_in = 8'h05;
    tick();
    chk("hk_af_en_off", 32'(af_en), 32'h00);
    chk("hk_pulse_2", 32'(toggle_pulse), 32'h1);
    btn_in = 8'h00;
    tick();
    chk("hk_pulse_2off", 32'(toggle_pulse), 32'h0);
    chk("hk_out_idle", 32'(btn_out), 32'h00);

    // A held before Select: no new A edge, no toggle
    btn_in = 8'h01;
    tick();
    btn_in = 8'h05;
    tick();
    chk("hk_noedge_af", 32'(af_en), 32'h00);
    chk("hk_noedge_pulse", 32'(toggle_pulse), 32'h0);
    btn_in = 8'h00;
    tick();

    // Simultaneous A+B rise with config write: config wins
    btn_in = 8'h04;
    tick();
    btn_in = 8'h07;
    cfg_we = 1'b1;
    cfg_en = 8'h80;
    tick();
    cfg_we = 1'b0;
    chk("sim_cfg_af_en", 32'(af_en), 32'h80);
    chk("sim_cfg_pulse", 32'(toggle_pulse), 32'h0);
    btn_in = 8'h00;
    tick();
    chk("sim_cfg_pulse2", 32'(toggle_pulse), 32'h0);
    // Same without config write: both bits flip
    btn_in = 8'h04;
    tick();
    btn_in = 8'h07;
    tick();
    chk("sim_flip_af_en", 32'(af_en), 32'h83);
    chk("sim_flip_pulse", 32'(toggle_pulse), 32'h1);
    chk("sim_flip_mask", 32'(btn_out), 32'h00);
    btn_in = 8'h00;
    tick();

    // Async reset mid-burst
    load_cfg(8'h01);
    btn_in = 8'h01;
    tick();
    tick();
    tick();
    chk("burst_high", 32'(btn_out), 32'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("async_btn_out", 32'(btn_out), 32'h00);
    chk("async_af_en", 32'(af_en), 32'h00);
    chk("async_pulse", 32'(toggle_pulse), 32'h0);
    btn_in = 8'h00;
    tick();
    reset = 1'b0;
    tick();
    load_cfg(8'h01);
    btn_in = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_rst_%0d", i), 32'(btn_out), 32'(af_exp(i)));
    end
    btn_in = 8'h00;
    tick();
    chk("post_rst_release", 32'(btn_out), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/autofire_ctrl.md
Name: autofire_ctrl

Overview:
- Per-controller autofire scheduler between the controller-port sampler and the NES joypad shift register.
- Owns one shared autofire timebase. Decides which of the 8 buttons receive the autofire toggle.
- Per-button enable mask is loaded from a config write or toggled by an in-game hotkey combo (Select + A/B).

Parameters:
- FREQ, 37_800_000, clk frequency in Hz.
- FIRERATE, 10, autofire press rate in Hz; half-period DELAY = FREQ/FIRERATE/2 cycles (must be >= 2).
- HOTKEY, 2, btn_in bit index used as the combo modifier (Select).
- AF_DEFAULT, 8'h00, reset value of the enable mask.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  8  live buttons, already synchronised to clk; bit0 A, bit1 B, bit2 Select, bit3 Start, bits4-7 Up/Down/Left/Right; 1 = pressed.
- cfg_we  in  1  one-cycle strobe that loads cfg_en into the mask.
- cfg_en  in  8  new autofire enable mask.
- btn_out  out  8  buttons after autofire and combo masking, registered.
- af_en  out  8  current autofire enable mask.
- toggle_pulse  out  1  one-cycle pulse when the hotkey toggles a mask bit.

Behaviour:
- Reset (async, active-high): timer=0, phase=0, btn_prev=0, combo=0, btn_out=0, toggle_pulse=0, af_en=AF_DEFAULT.
- Shared timebase:
  - timer width is $clog2(DELAY). af_active = |(btn_in & af_en).
  - If af_active is 0: timer<=0 and phase<=0 every cycle.
  - If af_active is 1: phase<=~phase when timer==0; timer increments and wraps to 0 after DELAY-1.
  - All held autofire buttons share phase. A button joining mid-period inherits the current phase; it does not restart it.
- Output (registered):
  - Base value: btn_out[i] <= btn_in[i] & (~af_en[i] | phase).
  - Non-autofire bits: latency 1 cycle.
  - Autofire bit pressed from idle:
    - Low on the first output cycle.
    - High from 2 cycles after the first sampled press.
    - Then toggles every DELAY cycles; period 2*DELAY, 50% duty.
  - Release: btn_out bit goes 0 one cycle after btn_in falls.
  - Once all autofire buttons are released, the next press restarts the timebase from 0.
- Hotkey:
  - rise[i] = btn_in[i] & ~btn_prev[i]; btn_prev <= btn_in every cycle.
  - If btn_in[HOTKEY]=1 and rise[0]: af_en[0] flips. Same for rise[1] and af_en[1].
  - Both rising in the same cycle: both flip.
  - On any flip: toggle_pulse=1 for exactly one cycle, and combo<=1.
  - combo clears on the cycle btn_in[HOTKEY]=0 is sampled.
  - While combo=1: btn_out bits 0, 1 and HOTKEY are forced 0, so the game never sees the combo.
  - Select+A without a new A edge (A pressed before Select) does not toggle.
- Config:
  - cfg_we=1 loads af_en<=cfg_en and has priority over a same-cycle hotkey toggle; that toggle is dropped and toggle_pulse stays 0.
  - Mask changes take effect on btn_out the next cycle. A bit disabled while held reverts to pass-through with no glitch beyond one cycle.
- Reset mid-burst: all outputs go to 0 immediately. After release, the first press behaves as from idle.

Test Plan (FREQ=100, FIRERATE=10 -> DELAY=5):
- Plain pass-through: af_en=0; btn_in=8'h09 at cycle 0 -> btn_out=8'h09 at cycle 1; release -> 8'h00 the next cycle.
- Autofire on A:
  - Stimulus: cfg_we with cfg_en=8'h01, then hold A for 30 cycles.
  - Required: btn_out[0] is 0,1,1,1,1,1,0,0,0,0,0,1... starting at press+1, period 10.
  - Release A -> btn_out[0]=0 the next cycle and timer=0.
- Shared phase:
  - Stimulus: af_en=8'h03; hold A, then press B 7 cycles later.
  - Required: btn_out[1] equals btn_out[0] from B's press+1 onward.
  - Releasing A alone does not reset the timer while B is held.
- Hotkey toggle:
  - Stimulus: hold Select, then press A.
  - Required: af_en goes 0x00->0x01 one cycle later; toggle_pulse high for 1 cycle; btn_out bits 0 and 2 stay 0 until Select is released.
  - Repeat the combo -> af_en back to 0x00.
- Simultaneous events:
  - Select held, A and B rise together with cfg_we=1, cfg_en=8'h80 -> af_en=8'h80 and no toggle_pulse.
  - Same stimulus without cfg_we -> af_en flips bits 0 and 1.
- Async reset mid-burst:
  - Assert reset while A autofires at phase=1 -> btn_out=0 and af_en=AF_DEFAULT before the next clk edge.
  - Deassert reset -> behaviour restarts from idle.
